// File: rtl/cnn_conv_ctrl.sv
// cnn_conv_ctrl: loads 3x3 weights, fetches every 3x3 image window through one read port
// and streams the conv results of the (H-2)x(W-2) valid positions over valid/ready.
module cnn_conv_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DIM_WIDTH  = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [ADDR_WIDTH-1:0]   img_base_i,
   input  logic [ADDR_WIDTH-1:0]   w_base_i,
   input  logic [DIM_WIDTH-1:0]    img_w_i,
   input  logic [DIM_WIDTH-1:0]    img_h_i,
   output logic                    rd_req_o,
   output logic [ADDR_WIDTH-1:0]   rd_addr_o,
   input  logic                    rd_gnt_i,
   input  logic                    rd_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   rd_rdata_i,
   output logic [9*DATA_WIDTH-1:0] window_o,
   output logic [9*DATA_WIDTH-1:0] weight_o,
   input  logic [ACC_WIDTH-1:0]    conv_out_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [ACC_WIDTH-1:0]    out_data_o,
   output logic [DIM_WIDTH-1:0]    out_row_o,
   output logic [DIM_WIDTH-1:0]    out_col_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);
   typedef enum logic [2:0] {IDLE, LOAD_W, FETCH, CONV, OUT, DONE} state_t;
   localparam logic [DIM_WIDTH-1:0] THREE = DIM_WIDTH'(3);
   state_t state, state_n;
   logic [ADDR_WIDTH-1:0] img_base, w_base;
   logic [DIM_WIDTH-1:0] img_w, img_h, r, c;
   logic [1:0] i, j;
   logic [3:0] k;
   logic pend, err, loading, take, last_el, last_col, last_row;
   assign k = {2'b00, i} * 4'd3 + {2'b00, j};
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      loading = state == LOAD_W || state == FETCH;
      rd_req_o = loading && !pend;
      rd_addr_o = state == LOAD_W ? w_base + ADDR_WIDTH'(k)
                : state == FETCH  ? img_base + (ADDR_WIDTH'(r) + ADDR_WIDTH'(i)) * ADDR_WIDTH'(img_w)
                                    + ADDR_WIDTH'(c) + ADDR_WIDTH'(j)
                : '0;
      // data is only accepted for our own request: granted earlier or in this very cycle
      take = loading && rd_rvalid_i && (pend || rd_gnt_i);
      last_el = i == 2'd2 && j == 2'd2;
      last_col = c == img_w - THREE;
      last_row = r == img_h - THREE;
      busy_o = state != IDLE;
      done_o = state == DONE;
      err_o = done_o && err;
      out_valid_o = state == OUT;
      state_n = state;
      case (state)
         IDLE:    if (start_i) state_n = (img_w_i < THREE || img_h_i < THREE) ? DONE : LOAD_W;
         LOAD_W:  if (take && last_el) state_n = FETCH;
         FETCH:   if (take && last_el) state_n = CONV;
         CONV:    state_n = OUT;
         OUT:     if (out_ready_i) state_n = (last_col && last_row) ? DONE : FETCH;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         img_base <= '0;
         w_base <= '0;
         img_w <= '0;
         img_h <= '0;
         r <= '0;
         c <= '0;
         i <= '0;
         j <= '0;
         pend <= 1'b0;
         err <= 1'b0;
         weight_o <= '0;
         window_o <= '0;
         out_data_o <= '0;
         out_row_o <= '0;
         out_col_o <= '0;
      end else begin
         if (state == IDLE && start_i) begin
            img_base <= img_base_i;
            w_base <= w_base_i;
            img_w <= img_w_i;
            img_h <= img_h_i;
            err <= img_w_i < THREE || img_h_i < THREE;
            r <= '0;
            c <= '0;
            i <= '0;
            j <= '0;
            pend <= 1'b0;
         end
         if (loading) pend <= !take && (pend || rd_gnt_i);
         if (take) begin
            if (state == LOAD_W) weight_o[k*DATA_WIDTH +: DATA_WIDTH] <= rd_rdata_i;
            else window_o[k*DATA_WIDTH +: DATA_WIDTH] <= rd_rdata_i;
            j <= j == 2'd2 ? 2'd0 : j + 2'd1;
            if (j == 2'd2) i <= last_el ? 2'd0 : i + 2'd1;
         end
         if (state == CONV) begin
            out_data_o <= conv_out_i;
            out_row_o <= r;
            out_col_o <= c;
         end
         if (state == OUT && out_ready_i) begin
            c <= last_col ? '0 : c + DIM_WIDTH'(1);
            if (last_col) r <= r + DIM_WIDTH'(1);
         end
      end
   end
endmodule
